// File: rtl/fifo_pkg.sv
// Shared types and helpers for the stream FIFO: the stored entry layout and
// the width of an occupancy count able to represent a full FIFO.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 32;

   // Entry as held in the RAM: end-of-packet marker above the payload.
   typedef struct packed {
      logic                       last;
      logic [FIFO_DATA_WIDTH-1:0] data;
   } fifo_entry_t;

   function automatic int fifo_cw(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port. A write to
// the address being read in the same cycle is forwarded to the read register.
module fifo_sdp_ram #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Write-first forwarding keeps rd_data equal to the current RAM head even
   // when the head was written at the same edge it became the read address.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == rd_addr)) begin
         rd_data <= wr_data;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock valid/ready stream FIFO with a first-word-fall-through output
// register, packet-end sideband, occupancy count, threshold flags and flush.
module axis_sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 1,
   localparam int CW        = fifo_cw(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CW-1:0]         count,
   output logic                  almost_full,
   output logic                  almost_empty
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   // Handshake contract: a transfer happens on a rising edge where valid and
   // ready are both high; ready never depends combinationally on the far side.

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr_nxt;
   logic [AW-1:0] rd_ptr_nxt;
   logic [CW-1:0] count_nxt;
   logic          clear;
   logic          wr_fire;
   logic          rd_fire;
   logic          ram_empty;
   logic          stage_free;
   logic          load_ram;
   logic          load_in;
   logic          ram_wr;
   logic          out_valid_nxt;
   entry_t        in_entry;
   entry_t        ram_q;

   assign clear    = rst | flush;
   assign in_ready = !rst && !flush && (count != CW'(DEPTH));
   assign wr_fire  = in_valid & in_ready;
   assign rd_fire  = out_valid & out_ready;
   assign in_entry = '{last: in_last, data: in_data};

   // The output register holds one of the counted entries whenever valid.
   assign ram_empty  = (count == CW'(out_valid));
   assign stage_free = !out_valid || rd_fire;

   always_comb begin
      load_ram      = 1'b0;
      load_in       = 1'b0;
      ram_wr        = 1'b0;
      out_valid_nxt = out_valid && !rd_fire;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      count_nxt     = count;
      if (clear) begin
         wr_ptr_nxt    = '0;
         rd_ptr_nxt    = '0;
         count_nxt     = '0;
         out_valid_nxt = 1'b0;
      end else begin
         // RAM head has priority; a write only bypasses into an empty FIFO.
         load_ram      = stage_free && !ram_empty;
         load_in       = stage_free && ram_empty && wr_fire;
         ram_wr        = wr_fire && !load_in;
         out_valid_nxt = (out_valid && !rd_fire) || load_ram || load_in;
         wr_ptr_nxt    = wr_ptr + AW'(ram_wr);
         rd_ptr_nxt    = rd_ptr + AW'(load_ram);
         count_nxt     = count + CW'(wr_fire) - CW'(rd_fire);
      end
   end

   always_ff @(posedge clk) begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      if (rst) begin
         out_data <= '0;
         out_last <= 1'b0;
      end else if (load_ram) begin
         out_data <= ram_q.data;
         out_last <= ram_q.last;
      end else if (load_in) begin
         out_data <= in_entry.data;
         out_last <= in_entry.last;
      end
   end

   // Reading at the next read pointer keeps ram_q aligned with the RAM head.
   fifo_sdp_ram #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wr),
      .wr_addr (wr_ptr),
      .wr_data (in_entry),
      .rd_addr (rd_ptr_nxt),
      .rd_data (ram_q)
   );

   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo: drivers push expected entries on each
// accepted write; a monitor pops and compares on every accepted read.
module tb_axis_sync_fifo;

   localparam int DATA_WIDTH = 32;
   localparam int DEPTH      = 16;
   localparam int CW         = $clog2(DEPTH + 1);

   logic                  clk;
   logic                  rst;
   logic                  flush;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [CW-1:0]         count;
   logic                  almost_full;
   logic                  almost_empty;

   int n_total;
   int n_pass;
   logic prod_done;
   logic [DATA_WIDTH:0] exp_q[$];

   axis_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AF_THRESH  (DEPTH - 2),
      .AE_THRESH  (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: push on accepted write, pop and compare on accepted read.
   always @(negedge clk) begin
      logic [DATA_WIDTH:0] exp_e;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_read", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_e = exp_q.pop_front();
            check("read_entry", 64'({out_last, out_data}), 64'(exp_e));
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back({in_last, in_data});
      end
      if (!rst) begin
         check("count_bound", 64'(count <= CW'(DEPTH)), 64'd1);
      end
   end

   // Drivers
   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_WIDTH-1:0] d, input logic l);
      logic ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         to_drive();
      end
      if (!ok) check("send_timeout", 64'd0, 64'd1);
      to_drive();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      logic ok;
      ok        = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (count == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_done", 64'(ok), 64'd1);
      to_drive();
      out_ready = 1'b0;
   endtask

   initial begin
      n_total   = 0;
      n_pass    = 0;
      prod_done = 1'b0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_almost_empty", 64'(almost_empty), 64'd1);
      check("rst_almost_full", 64'(almost_full), 64'd0);
      to_drive();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      to_drive();

      // Write 1..5 with the consumer stalled
      send(32'h1, 1'b0);
      @(negedge clk);
      check("fwft_out_valid", 64'(out_valid), 64'd1);
      check("fwft_out_data", 64'(out_data), 64'h1);
      to_drive();
      for (int i = 2; i <= 5; i++) send(32'(i), 1'b0);
      @(negedge clk);
      check("five_count", 64'(count), 64'd5);
      check("five_head", 64'(out_data), 64'h1);
      check("five_almost_empty", 64'(almost_empty), 64'd0);
      to_drive();
      drain();

      // Fill to DEPTH, then a write during a read of the full FIFO
      for (int i = 0; i < 13; i++) send(32'h100 + 32'(i), 1'b0);
      @(negedge clk);
      check("af_13", 64'(almost_full), 64'd0);
      to_drive();
      send(32'h10D, 1'b0);
      @(negedge clk);
      check("af_14", 64'(almost_full), 64'd1);
      check("count_14", 64'(count), 64'd14);
      to_drive();
      send(32'h10E, 1'b0);
      send(32'h10F, 1'b1);
      @(negedge clk);
      check("full_count", 64'(count), 64'd16);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_almost_full", 64'(almost_full), 64'd1);
      to_drive();
      in_valid  = 1'b1;
      in_data   = 32'hDEAD;
      out_ready = 1'b1;
      @(negedge clk);
      check("full_refuses_write", 64'(in_ready), 64'd0);
      to_drive();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      check("full_read_count", 64'(count), 64'd15);
      check("ready_after_read", 64'(in_ready), 64'd1);
      to_drive();
      drain();

      // Continuous streaming 0..63
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 64; i++) begin
         in_data = 32'(i);
         in_last = (i == 63);
         @(negedge clk);
         check("stream_count", 64'(count), (i == 0) ? 64'd0 : 64'd1);
         check("stream_out_valid", 64'(out_valid), (i == 0) ? 64'd0 : 64'd1);
         to_drive();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("stream_tail_count", 64'(count), 64'd1);
      to_drive();
      drain();

      // Random valid/ready with packet ends every 7th word
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 1)) to_drive();
               send(32'hC000_0000 + 32'(i * 3), (i % 7) == 6);
            end
            prod_done = 1'b1;
         end
         begin
            for (int k = 0; k < 5000; k++) begin
               to_drive();
               out_ready = 1'($urandom_range(0, 1));
               if (prod_done && count == 0) break;
            end
         end
      join
      out_ready = 1'b0;
      check("random_all_read", 64'(exp_q.size()), 64'd0);

      // Flush with 10 entries while a read completes
      for (int i = 0; i < 10; i++) send(32'h200 + 32'(i), 1'b0);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hBAD;
      to_drive();
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_almost_empty", 64'(almost_empty), 64'd1);
      to_drive();
      send(32'hAA, 1'b1);
      @(negedge clk);
      check("post_flush_valid", 64'(out_valid), 64'd1);
      check("post_flush_head", 64'({out_last, out_data}), {31'd0, 1'b1, 32'hAA});
      to_drive();
      drain();

      // Reset mid-stream with 6 entries held
      send(32'h5A5A, 1'b1);
      for (int i = 1; i < 6; i++) send(32'h300 + 32'(i), 1'b0);
      @(negedge clk);
      check("pre_rst_count", 64'(count), 64'd6);
      to_drive();
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      to_drive();
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mrst_count", 64'(count), 64'd0);
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_out_data", 64'(out_data), 64'd0);
      check("mrst_out_last", 64'(out_last), 64'd0);
      check("mrst_almost_empty", 64'(almost_empty), 64'd1);
      check("mrst_almost_full", 64'(almost_full), 64'd0);
      check("mrst_in_ready", 64'(in_ready), 64'd1);
      to_drive();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
